rate_tick_gen: RTL and testbench

//  Upstream enable generator for the 8-bit T-flip-flop display counter.

---
 rtl/rate_tick_gen.sv | 113 +++++++++++
 tb/tb_rate_tick_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rate_tick_gen.sv
// rate_tick_gen: one-cycle Tick enable for the display counter.
// Run mode divides the board clock by a Speed-selected ratio.
// Step mode emits one Tick per debounced Step press.
module rate_tick_gen #(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned CNT_W           = 28,
    parameter int unsigned DB_W            = 20
) (
    input  logic       Clk,
    input  logic       Clear,
    input  logic       Enable,
    input  logic       Mode,
    input  logic [1:0] Speed,
    input  logic       Step,
    output logic       Tick
);

    typedef enum logic [1:0] {
        SPD_CONT = 2'b00,
        SPD_1X   = 2'b01,
        SPD_2X   = 2'b10,
        SPD_4X   = 2'b11
    } speed_e;

    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_STEP = 1'b1
    } mode_e;

    localparam logic [CNT_W-1:0] RELOAD_1X = CNT_W'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0] RELOAD_2X = CNT_W'(2 * CLK_HZ - 1);
    localparam logic [CNT_W-1:0] RELOAD_4X = CNT_W'(4 * CLK_HZ - 1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    // Downcounter start value for a given rate (DIV-1; 0 for continuous)
    function automatic logic [CNT_W-1:0] reload_val(input speed_e s);
        reload_val = '0;
        unique case (s)
            SPD_CONT: reload_val = '0;
            SPD_1X:   reload_val = RELOAD_1X;
            SPD_2X:   reload_val = RELOAD_2X;
            SPD_4X:   reload_val = RELOAD_4X;
        endcase
    endfunction

    logic [CNT_W-1:0] cnt;
    logic [1:0]       speed_q;
    logic             mode_q;

    logic             sync_a;
    logic             sync_b;
    logic             debounced;
    logic             debounced_q;
    logic [DB_W-1:0]  db_cnt;
    logic             press;

    // Step pushbutton: synchronise, debounce, remember previous level for edge detect
    always_ff @(posedge Clk) begin
        if (!Clear) begin
            sync_a      <= 1'b1;
            sync_b      <= 1'b1;
            debounced   <= 1'b1;
            debounced_q <= 1'b1;
            db_cnt      <= '0;
        end else begin
            sync_a      <= Step;
            sync_b      <= sync_a;
            debounced_q <= debounced;
            if (sync_b == debounced) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                debounced <= sync_b;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Press is the released-to-pressed transition of the debounced level
    always_comb begin
        press = debounced_q & ~debounced;
    end

    // Rate divider and Tick register; a Speed/Mode change restarts the period
    always_ff @(posedge Clk) begin
        if (!Clear) begin
            cnt     <= reload_val(speed_e'(Speed));
            speed_q <= Speed;
            mode_q  <= Mode;
            Tick    <= 1'b0;
        end else if ((Speed != speed_q) || (Mode != mode_q)) begin
            cnt     <= reload_val(speed_e'(Speed));
            speed_q <= Speed;
            mode_q  <= Mode;
            Tick    <= 1'b0;
        end else if (!Enable) begin
            Tick <= 1'b0;
        end else if (mode_q == MODE_STEP) begin
            Tick <= press;
        end else if (speed_e'(speed_q) == SPD_CONT) begin
            Tick <= 1'b1;
        end else if (cnt == '0) begin
            cnt  <= reload_val(speed_e'(speed_q));
            Tick <= 1'b1;
        end else begin
            cnt  <= cnt - 1'b1;
            Tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rate_tick_gen.sv
// Bench for rate_tick_gen with a small clock ratio and short debounce.
module tb_rate_tick_gen;

    localparam int unsigned CLK_HZ = 10;
    localparam int unsigned DEB    = 4;

    logic       Clk = 1'b0;
    logic       Clear;
    logic       Enable;
    logic       Mode;
    logic [1:0] Speed;
    logic       Step;
    logic       Tick;

    always #5 Clk = ~Clk;

    rate_tick_gen #(
        .CLK_HZ(CLK_HZ),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(8),
        .DB_W(4)
    ) dut (
        .Clk(Clk),
        .Clear(Clear),
        .Enable(Enable),
        .Mode(Mode),
        .Speed(Speed),
        .Step(Step),
        .Tick(Tick)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, clock it, sample just after the edge
    task automatic cyc(input logic clr, input logic en, input logic md,
                       input logic [1:0] sp, input logic st);
        Clear  = clr;
        Enable = en;
        Mode   = md;
        Speed  = sp;
        Step   = st;
        @(posedge Clk);
        #1;
    endtask

    // Run n cycles with fixed inputs, count ticks and note the first tick edge
    task automatic run_span(input int n, input logic en, input logic md,
                            input logic [1:0] sp, input logic st,
                            output int ticks, output int first);
        ticks = 0;
        first = -1;
        for (int i = 1; i <= n; i++) begin
            cyc(1'b1, en, md, sp, st);
            if (Tick === 1'b1) begin
                ticks++;
                if (first < 0) first = i;
            end
        end
    endtask

    // ---------------- reference model ----------------
    logic       m_tick;
    logic [1:0] m_spd;
    logic       m_mode;
    int         m_en_edges;
    logic       m_deb;
    logic       m_fell;
    logic       h[$];

    function automatic int div_of(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return CLK_HZ;
            2'b10:   return 2 * CLK_HZ;
            default: return 4 * CLK_HZ;
        endcase
    endfunction

    // Tick falls on every DIV-th enabled edge since the last restart; the
    // debounced level flips once the last DEB synchronised samples all disagree.
    task automatic model_edge(input logic clr, input logic en, input logic md,
                              input logic [1:0] sp, input logic st);
        logic prev;
        logic all_diff;
        int   idx;
        if (!clr) begin
            m_tick     = 1'b0;
            m_spd      = sp;
            m_mode     = md;
            m_en_edges = 0;
            m_deb      = 1'b1;
            m_fell     = 1'b0;
            h.delete();
            h.push_back(1'b1);
            h.push_back(1'b1);
        end else begin
            if (sp != m_spd || md != m_mode) begin
                m_tick     = 1'b0;
                m_spd      = sp;
                m_mode     = md;
                m_en_edges = 0;
            end else if (!en) begin
                m_tick = 1'b0;
            end else if (m_mode) begin
                m_tick = m_fell;
            end else begin
                m_en_edges++;
                m_tick = ((m_en_edges % div_of(m_spd)) == 0);
            end
            prev     = m_deb;
            all_diff = 1'b1;
            for (int i = 0; i < int'(DEB); i++) begin
                idx = h.size() - 2 - i;
                if (idx < 0) all_diff = 1'b0;
                else if (h[idx] == m_deb) all_diff = 1'b0;
            end
            if (all_diff) m_deb = ~m_deb;
            m_fell = prev & ~m_deb;
            h.push_back(st);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       clr;
        logic       en;
        logic       md;
        logic [1:0] sp;
        logic       st;
        logic       exp;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input logic clr, input logic en, input logic md,
                                input logic [1:0] sp, input logic st, input logic exp);
        vec_t v;
        v.clr = clr; v.en = en; v.md = md; v.sp = sp; v.st = st; v.exp = exp;
        return v;
    endfunction

    initial begin
        int t;
        int f;
        int ta;
        int tb;
        logic       r_cl;
        logic       r_en;
        logic       r_md;
        logic [1:0] r_sp;
        logic       r_st;

        tbl[0]  = mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);  // reset
        tbl[1]  = mk(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);  // continuous
        tbl[2]  = mk(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
        tbl[3]  = mk(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
        tbl[4]  = mk(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);  // disabled
        tbl[5]  = mk(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
        tbl[6]  = mk(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);  // reload to 1x
        for (int i = 7; i <= 15; i++)
            tbl[i] = mk(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        tbl[16] = mk(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1);  // 10th edge
        tbl[17] = mk(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        tbl[18] = mk(1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0);  // mode reload
        tbl[19] = mk(1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            cyc(tbl[i].clr, tbl[i].en, tbl[i].md, tbl[i].sp, tbl[i].st);
            check($sformatf("table[%0d]", i), Tick, tbl[i].exp);
        end

        // Run 1x: ticks at edges 10, 20, 30 after reset release
        cyc(1'b0, 1'b1, 1'b0, 2'b01, 1'b1);
        check("reset_tick", Tick, 1'b0);
        for (int e = 1; e <= 30; e++) begin
            cyc(1'b1, 1'b1, 1'b0, 2'b01, 1'b1);
            check($sformatf("run1x_edge%0d", e), Tick, (e % 10) == 0);
        end

        // Switch to 4x: reload edge silent, then period 40
        cyc(1'b1, 1'b1, 1'b0, 2'b11, 1'b1);
        check("reload_4x_tick", Tick, 1'b0);
        run_span(40, 1'b1, 1'b0, 2'b11, 1'b1, t, f);
        check("run4x_count", t, 1);
        check("run4x_edge", f, 40);

        // Enable low for 5 cycles at cnt=3 delays the tick by 5
        cyc(1'b0, 1'b1, 1'b0, 2'b01, 1'b1);
        run_span(6, 1'b1, 1'b0, 2'b01, 1'b1, t, f);
        check("pause_pre", t, 0);
        run_span(5, 1'b0, 1'b0, 2'b01, 1'b1, t, f);
        check("pause_hold", t, 0);
        run_span(4, 1'b1, 1'b0, 2'b01, 1'b1, t, f);
        check("pause_count", t, 1);
        check("pause_edge", f, 4);

        // Speed change on the terminal-count cycle wins over the tick
        cyc(1'b0, 1'b1, 1'b0, 2'b01, 1'b1);
        run_span(9, 1'b1, 1'b0, 2'b01, 1'b1, t, f);
        check("tc_pre", t, 0);
        cyc(1'b1, 1'b1, 1'b0, 2'b10, 1'b1);
        check("tc_reload_tick", Tick, 1'b0);
        run_span(20, 1'b1, 1'b0, 2'b10, 1'b1, t, f);
        check("tc_count", t, 1);
        check("tc_edge", f, 20);

        // Step mode: bounce then a held press gives exactly one tick
        cyc(1'b0, 1'b1, 1'b1, 2'b01, 1'b1);
        run_span(3, 1'b1, 1'b1, 2'b01, 1'b1, t, f);
        check("step_idle", t, 0);
        run_span(3, 1'b1, 1'b1, 2'b01, 1'b0, ta, f);
        run_span(2, 1'b1, 1'b1, 2'b01, 1'b1, tb, f);
        check("step_bounce", ta + tb, 0);
        run_span(10, 1'b1, 1'b1, 2'b01, 1'b0, t, f);
        check("step_count", t, 1);
        check("step_latency", f, 7);
        run_span(12, 1'b1, 1'b1, 2'b01, 1'b1, t, f);
        check("step_release", t, 0);

        // Clear mid-period discards the running period
        cyc(1'b0, 1'b1, 1'b0, 2'b01, 1'b1);
        run_span(5, 1'b1, 1'b0, 2'b01, 1'b1, t, f);
        check("clr_pre", t, 0);
        cyc(1'b0, 1'b1, 1'b0, 2'b01, 1'b1);
        check("clr_tick", Tick, 1'b0);
        run_span(10, 1'b1, 1'b0, 2'b01, 1'b1, t, f);
        check("clr_count", t, 1);
        check("clr_edge", f, 10);

        // Randomised run against the reference model
        r_cl = 1'b0; r_en = 1'b1; r_md = 1'b0; r_sp = 2'b01; r_st = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            r_cl = (n == 0) ? 1'b0 : ($urandom_range(199) != 0);
            if (r_en) r_en = ($urandom_range(39) != 0);
            else      r_en = ($urandom_range(3) == 0);
            if ($urandom_range(79) == 0) r_md = ~r_md;
            if ($urandom_range(99) == 0) r_sp = 2'($urandom_range(3));
            if ($urandom_range(4) == 0)  r_st = ~r_st;
            cyc(r_cl, r_en, r_md, r_sp, r_st);
            model_edge(r_cl, r_en, r_md, r_sp, r_st);
            check($sformatf("random[%0d]", n), Tick, m_tick);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
